// File: rtl/pipelined_alu_seq.sv
// pipelined_alu_seq: handshaked multi-cycle ALU between register-file read and writeback.
// Single-cycle logic/arith ops, 1-bit/cycle shifter, full flag set.
// Optional shift-add multiplier (op 10) enabled by defining ALU_MUL_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand bundle
// SHIFT | iterative shift, one bit per cycle until the counter expires
// MUL   | shift-add multiply, one partial product per cycle (ALU_MUL_EN only)
// DONE  | result is published on the first cycle, then held until out_ready
module pipelined_alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_ZERO = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_MUL_EN
    S_MUL   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               carry_p, ovf_p, ill_p;
  logic               out_valid_q;

  logic               is_shift;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_ill;
  logic [WIDTH-1:0]   sh_next;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
`endif

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // Shift count saturates at WIDTH: larger amounts behave as a full shift-out.
  always_comb begin
    if (b >= WIDTH'(WIDTH)) k = SHAMT_W'(WIDTH);
    else                    k = SHAMT_W'(b);
  end

  // Single-cycle result and flags for the incoming bundle; shifts pass a through as the seed.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_ZERO: alu_res = '0;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`ifdef ALU_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit shift step on the working value.
  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, acc[WIDTH-1:1]};
      default: sh_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_MUL_EN
  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    prod_nxt = mplier[0] ? (prod + mcand) : prod;
  end
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL)                   state_nxt = S_MUL;
          else
`endif
          if (is_shift && (k != '0))          state_nxt = S_SHIFT;
          else                                state_nxt = S_DONE;
        end
      end
      S_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:   if (cnt == SHAMT_W'(1)) state_nxt = S_DONE;
`endif
      S_DONE:  if (out_valid_q && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = out_valid_q;
  end

  // Datapath: latch on accept, iterate in SHIFT/MUL, publish and hold in DONE.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_q         <= '0;
      acc          <= '0;
      cnt          <= '0;
      carry_p      <= 1'b0;
      ovf_p        <= 1'b0;
      ill_p        <= 1'b0;
      out_valid_q  <= 1'b0;
      result       <= '0;
      flag_zero    <= 1'b0;
      flag_neg     <= 1'b0;
      flag_carry   <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_illegal <= 1'b0;
`ifdef ALU_MUL_EN
      mcand        <= '0;
      mplier       <= '0;
      prod         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            acc     <= alu_res;
            carry_p <= alu_carry;
            ovf_p   <= alu_ovf;
            ill_p   <= alu_ill;
            cnt     <= k;
`ifdef ALU_MUL_EN
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            prod    <= '0;
            if (op == OP_MUL) cnt <= SHAMT_W'(WIDTH);
`endif
          end
        end
        S_SHIFT: begin
          acc <= sh_next;
          cnt <= cnt - SHAMT_W'(1);
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          prod    <= prod_nxt;
          mcand   <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier  <= {1'b0, mplier[WIDTH-1:1]};
          cnt     <= cnt - SHAMT_W'(1);
          acc     <= prod_nxt[WIDTH-1:0];
          carry_p <= |prod_nxt[2*WIDTH-1:WIDTH];
        end
`endif
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q  <= 1'b1;
            result       <= acc;
            flag_zero    <= (acc == '0);
            flag_neg     <= acc[WIDTH-1];
            flag_carry   <= carry_p;
            flag_ovf     <= ovf_p;
            flag_illegal <= ill_p;
          end else if (out_ready) begin
            out_valid_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipelined_alu_seq.md
Name: pipelined_alu_seq

Overview:
- Parametrised, handshaked, multi-cycle ALU for the datapath. Successor to the single-cycle 16-bit ALU.
- Adds four things:
  - configurable width;
  - valid/ready handshakes on input and output;
  - iterative barrel-free shifter (1 bit/cycle);
  - full flag set: zero, negative, carry, overflow, illegal-op.
- Sits between register-file read and writeback; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- SHAMT_W, $clog2(WIDTH)+1, width of internal shift counter; holds values up to WIDTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle.
- op  in  4  operation code, see Behaviour.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand / shift amount.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- flag_zero  out  1  result == 0.
- flag_neg  out  1  result[WIDTH-1].
- flag_carry  out  1  carry-out (ADD) / no-borrow (SUB); 0 otherwise.
- flag_ovf  out  1  signed overflow (ADD/SUB); 0 otherwise.
- flag_illegal  out  1  op not supported.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state=IDLE;
  - in_ready=1, out_valid=0;
  - result and all flags = 0.
  - Reset has priority over everything. It aborts an in-flight op, and no result is produced for it.
- Opcodes:
  - 0 ADD a+b; 1 SUB a-b; 2 OR; 3 AND (bitwise, not logical);
  - 4 SLL; 5 SRL; 6 XOR; 7 ZERO (result 0);
  - 8 SRA; 9 SLT (signed a<b → 1 else 0); 10 MUL (see Optional Feature);
  - 11–15 illegal.
- States: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready. Operands and op are latched.
  - Single-cycle ops (0–3, 6, 7, 9, illegal) → DONE.
  - Shift ops → SHIFT, with counter k = min(b, WIDTH) (unsigned compare on full b).
  - If k==0, a shift op goes straight to DONE with result=a.
- SHIFT:
  - One bit per cycle: SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates MSB.
  - k decrements each cycle. On k reaching 0 → DONE.
  - b ≥ WIDTH: SLL/SRL → 0, SRA → all sign bits, after exactly WIDTH shift cycles.
- DONE:
  - out_valid=1; result and flags stable.
  - in_ready=0 in all non-IDLE states.
  - Leaves to IDLE on out_ready=1. out_valid drops the next cycle.
  - Backpressure of arbitrary length must hold outputs unchanged.
- Latency, counted from the accept edge N:
  - out_valid rises at edge N+1 for single-cycle ops;
  - N+1+k for shifts;
  - N+1+WIDTH for MUL.
- Throughput: one accept per op. The earliest next accept is the edge after out_ready is sampled high in DONE.
- Width/arithmetic:
  - ADD/SUB computed at WIDTH+1 bits; result is truncated to WIDTH.
  - carry = bit WIDTH for ADD; for SUB, carry = NOT borrow (a ≥ b unsigned).
  - ovf = signs of operands agree (ADD) / differ (SUB) and the result sign differs from a.
- flag_zero/flag_neg are computed from the final result for every op, including illegal ops.
- Illegal op: result=0, flag_illegal=1, zero=1, and it follows single-cycle latency.
- out_ready asserted while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the source must hold its bundle.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - op 10 = unsigned shift-add multiply, one partial product per cycle in state MUL.
  - Runs WIDTH cycles. Result = low WIDTH bits of a*b.
  - flag_carry=1 if any high product bit is nonzero; flag_ovf=0.
- Undefined:
  - MUL state and multiplier logic are absent.
  - op 10 is illegal (flag_illegal=1, result 0, single-cycle).

Test Plan:
- WIDTH=16, ADD a=16'h7FFF, b=16'h0001 → out_valid at N+1, result=16'h8000, ovf=1, carry=0, neg=1, zero=0.
- SUB a=5, b=5 → result=0, zero=1, carry=1 (no borrow). SUB a=3, b=5 → result=16'hFFFE, carry=0, neg=1.
- SRA a=16'h8000, b=3 → out_valid exactly 4 cycles after accept, result=16'hF000. SLL a=16'h0001, b=20 → 17 cycles, result=0.
- ADD a=1, b=2 with out_ready held 0 for 5 cycles → result=3 stable, in_ready=0 throughout; accept of next bundle only after out_ready=1.
- Illegal op=4'hC → result=0, flag_illegal=1; with ALU_MUL_EN undefined, op 10 gives the same. With ALU_MUL_EN, op 10 a=300, b=300 → result=16'h5F90, carry=1, latency 17.
- RST_N=0 mid-SHIFT (k=7, cycle 3) → next edge: IDLE, in_ready=1, out_valid=0, no stale result emitted.
